// File: rtl/avalon_led_pio_blink.sv
// Avalon-MM LED output port with atomic set/clear/toggle registers and a
// hardware blink engine driven by a programmable half-period prescaler.
module avalon_led_pio_blink #(
    parameter int                  WIDTH        = 18,
    parameter int                  PERIOD_W     = 24,
    parameter logic [WIDTH-1:0]    RESET_VALUE  = '0,
    parameter logic [PERIOD_W-1:0] PERIOD_RESET = PERIOD_W'(2499999)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE = 3'd3;
    localparam logic [2:0] ADDR_BLINK  = 3'd4;
    localparam logic [2:0] ADDR_PERIOD = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    logic [WIDTH-1:0]    r_data;
    logic [WIDTH-1:0]    r_blinkEn;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_cnt;
    logic                r_phase;

    logic             w_write;
    logic             w_periodWrite;
    logic [WIDTH-1:0] w_wd;
    logic             w_unused;

    assign w_write       = chipselect & ~write_n;
    assign w_periodWrite = w_write && (address == ADDR_PERIOD);
    assign w_wd          = writedata[WIDTH-1:0];
    assign w_unused      = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data    <= RESET_VALUE;
            r_blinkEn <= '0;
            r_period  <= PERIOD_RESET;
        end else if (w_write) begin
            case (address)
                ADDR_DATA:   r_data    <= w_wd;
                ADDR_SET:    r_data    <= r_data | w_wd;
                ADDR_CLEAR:  r_data    <= r_data & ~w_wd;
                ADDR_TOGGLE: r_data    <= r_data ^ w_wd;
                ADDR_BLINK:  r_blinkEn <= w_wd;
                ADDR_PERIOD: r_period  <= writedata[PERIOD_W-1:0];
                default:     ;
            endcase
        end
    end

    // A PERIOD write restarts the half-period, overriding a terminal count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_periodWrite) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == r_period) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + PERIOD_W'(1);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata[WIDTH-1:0]    = r_data;
            ADDR_BLINK:  readdata[WIDTH-1:0]    = r_blinkEn;
            ADDR_PERIOD: readdata[PERIOD_W-1:0] = r_period;
            ADDR_STATUS: readdata[0]            = r_phase;
            default:     ;
        endcase
    end

    assign out_port = r_data & ~(r_blinkEn & {WIDTH{r_phase}});

endmodule

// File: tb/tb_avalon_led_pio_blink.sv
// Self-checking bench for avalon_led_pio_blink: directed vectors, blink timing
// corners, asynchronous reset, a WIDTH=8 instance and a randomized model run.
module tb_avalon_led_pio_blink;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [17:0] out_port;

    logic [2:0]  addr8;
    logic        cs8;
    logic        wn8;
    logic [31:0] wd8;
    logic [31:0] rd8;
    logic [7:0]  out8;

    int checks = 0;
    int errors = 0;

    // Reference model: registers plus the number of edges since the
    // prescaler was last restarted; phase is derived arithmetically.
    logic [17:0] mData;
    logic [17:0] mBlink;
    logic [23:0] mPeriod;
    int          sinceAnchor;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [17:0] expOut;
        logic [31:0] expRead;
    } vec_t;

    vec_t vecs[7];

    avalon_led_pio_blink dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    avalon_led_pio_blink #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (addr8),
        .chipselect (cs8),
        .write_n    (wn8),
        .writedata  (wd8),
        .readdata   (rd8),
        .out_port   (out8)
    );

    always #5 clk = ~clk;

    function automatic logic modelPhase();
        return ((sinceAnchor / (int'(mPeriod) + 1)) % 2) == 1;
    endfunction

    function automatic logic [17:0] modelOut();
        return mData & ~(mBlink & {18{modelPhase()}});
    endfunction

    function automatic logic [31:0] modelRead(input logic [2:0] a);
        case (a)
            3'd0:    return {14'd0, mData};
            3'd4:    return {14'd0, mBlink};
            3'd5:    return {8'd0, mPeriod};
            3'd6:    return {31'd0, modelPhase()};
            default: return 32'd0;
        endcase
    endfunction

    task automatic resetModel();
        mData       = '0;
        mBlink      = '0;
        mPeriod     = 24'd2499999;
        sinceAnchor = 0;
    endtask

    task automatic modelEdge(input logic wr, input logic [2:0] a, input logic [31:0] d);
        if (wr && a == 3'd5) begin
            mPeriod     = d[23:0];
            sinceAnchor = 0;
        end else begin
            sinceAnchor++;
            if (wr) begin
                case (a)
                    3'd0: mData  = d[17:0];
                    3'd1: mData  = mData | d[17:0];
                    3'd2: mData  = mData & ~d[17:0];
                    3'd3: mData  = mData ^ d[17:0];
                    3'd4: mBlink = d[17:0];
                    default: ;
                endcase
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one bus cycle from a falling edge, advances the model at the
    // rising edge and returns at the next falling edge with the bus idle.
    task automatic applyStimulus(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = d;
        @(posedge clk);
        modelEdge(cs && !wn, a, d);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic applyStimulus8(input logic wr, input logic [2:0] a, input logic [31:0] d);
        cs8   = wr;
        wn8   = !wr;
        addr8 = a;
        wd8   = d;
        @(posedge clk);
        @(negedge clk);
        cs8 = 1'b0;
        wn8 = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd5;
        writedata  = '0;
        cs8        = 1'b0;
        wn8        = 1'b1;
        addr8      = 3'd0;
        wd8        = '0;
        resetModel();

        #23;
        checkOutput("reset out_port", {14'd0, out_port}, 32'd0);
        checkOutput("reset PERIOD", readdata, 32'd2499999);
        address = 3'd0;
        #1;
        checkOutput("reset DATA", readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(1'b1, 1'b0, 3'd0, 32'h0003FFFF);
        checkOutput("DATA write out", {14'd0, out_port}, 32'h0003FFFF);
        checkOutput("DATA write read", readdata, 32'h0003FFFF);

        vecs[0] = '{1'b1, 3'd0, 32'h000000F0, 18'h0F0, 32'h0F0};
        vecs[1] = '{1'b1, 3'd1, 32'h0000000F, 18'h0FF, 32'h0};
        vecs[2] = '{1'b1, 3'd2, 32'h00000030, 18'h0CF, 32'h0};
        vecs[3] = '{1'b1, 3'd3, 32'h00000101, 18'h1CE, 32'h0};
        vecs[4] = '{1'b0, 3'd0, 32'h00000000, 18'h1CE, 32'h1CE};
        vecs[5] = '{1'b1, 3'd7, 32'h0003FFFF, 18'h1CE, 32'h0};
        vecs[6] = '{1'b0, 3'd4, 32'h00000000, 18'h1CE, 32'h0};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].wr, !vecs[i].wr, vecs[i].addr, vecs[i].data);
            checkOutput($sformatf("vec%0d out", i), {14'd0, out_port}, {14'd0, vecs[i].expOut});
            checkOutput($sformatf("vec%0d read", i), readdata, vecs[i].expRead);
        end

        applyStimulus(1'b1, 1'b0, 3'd0, 32'h3);
        applyStimulus(1'b1, 1'b0, 3'd4, 32'h1);
        applyStimulus(1'b1, 1'b0, 3'd5, 32'h3);
        for (int k = 0; k < 17; k++) begin
            if (k > 0) applyStimulus(1'b0, 1'b1, 3'd6, 32'h0);
            else begin
                address = 3'd6;
                #1;
            end
            checkOutput($sformatf("blink%0d out", k), {14'd0, out_port}, ((k / 4) % 2) ? 32'h2 : 32'h3);
            checkOutput($sformatf("blink%0d status", k), readdata, 32'((k / 4) % 2));
        end

        applyStimulus(1'b1, 1'b0, 3'd5, 32'h0);
        for (int k = 1; k < 7; k++) begin
            applyStimulus(1'b0, 1'b1, 3'd6, 32'h0);
            checkOutput($sformatf("period0 status%0d", k), readdata, 32'(k % 2));
        end

        applyStimulus(1'b1, 1'b0, 3'd5, 32'h3);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 3'd6, 32'h0);
        applyStimulus(1'b1, 1'b0, 3'd5, 32'h5);
        address = 3'd6;
        #1;
        checkOutput("precedence phase", readdata, 32'h0);
        for (int k = 1; k < 8; k++) begin
            applyStimulus(1'b0, 1'b1, 3'd6, 32'h0);
            checkOutput($sformatf("precedence status%0d", k), readdata, (k >= 6) ? 32'h1 : 32'h0);
        end

        for (int n = 0; n < 400; n++) begin
            logic [2:0]  a;
            logic [31:0] d;
            int          op;
            a  = 3'($urandom_range(0, 7));
            d  = $urandom;
            op = $urandom_range(0, 9);
            if (a == 3'd5) d = (d & 32'hFF000000) | 32'($urandom_range(0, 6));
            if (op < 5)      applyStimulus(1'b1, 1'b0, a, d);
            else if (op < 8) applyStimulus(1'b1, 1'b1, a, d);
            else             applyStimulus(1'b0, 1'b0, a, d);
            checkOutput($sformatf("rand%0d out", n), {14'd0, out_port}, {14'd0, modelOut()});
            checkOutput($sformatf("rand%0d read@%0d", n, a), readdata, modelRead(a));
        end

        applyStimulus(1'b1, 1'b0, 3'd0, 32'h3FFFF);
        applyStimulus(1'b1, 1'b0, 3'd4, 32'h1);
        applyStimulus(1'b1, 1'b0, 3'd5, 32'h2);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 3'd6, 32'h0);
        checkOutput("midblink status", readdata, 32'h1);
        checkOutput("midblink out", {14'd0, out_port}, 32'h3FFFE);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset out", {14'd0, out_port}, 32'h0);
        checkOutput("async reset status", readdata, 32'h0);
        address = 3'd4;
        #1;
        checkOutput("async reset blink", readdata, 32'h0);
        address = 3'd5;
        #1;
        checkOutput("async reset period", readdata, 32'd2499999);
        @(negedge clk);
        reset_n = 1'b1;
        resetModel();

        applyStimulus8(1'b1, 3'd0, 32'hFFFFFFFF);
        checkOutput("w8 read", rd8, 32'h000000FF);
        checkOutput("w8 out", {24'd0, out8}, 32'hFF);
        applyStimulus8(1'b1, 3'd7, 32'h0);
        checkOutput("w8 addr7 read", rd8, 32'h0);
        addr8 = 3'd0;
        #1;
        checkOutput("w8 addr7 ignored", rd8, 32'h000000FF);
        checkOutput("w8 addr7 out", {24'd0, out8}, 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
